// File: rtl/player_motion_ctrl.sv
// Player movement controller: prescaled one-hot direction moves with bounds clamping,
// walk-animation frame sequencing, and collision/found tracking for N_OBJ collectables.
module player_motion_ctrl #(
  parameter int COORD_W  = 9,
  parameter int TICK_DIV = 1048576,
  parameter int STEP     = 1,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 300,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 220,
  parameter int START_X  = 40,
  parameter int START_Y  = 130,
  parameter int N_OBJ    = 3,
  parameter int HIT_R    = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     load_start,
  input  logic [3:0]               move_req,
  input  logic [N_OBJ*COORD_W-1:0] obj_x,
  input  logic [N_OBJ*COORD_W-1:0] obj_y,
  input  logic [N_OBJ-1:0]         obj_active,
  output logic [COORD_W-1:0]       player_x,
  output logic [COORD_W-1:0]       player_y,
  output logic [3:0]               player_state,
  output logic                     tick,
  output logic [N_OBJ-1:0]         found,
  output logic                     found_pulse,
  output logic [3:0]               found_count,
  output logic                     all_found
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int EW    = COORD_W + 1;

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [EW-1:0]      STEP_E   = EW'(STEP);
  localparam logic [EW-1:0]      X_MIN_E  = EW'(X_MIN);
  localparam logic [EW-1:0]      X_MAX_E  = EW'(X_MAX);
  localparam logic [EW-1:0]      Y_MIN_E  = EW'(Y_MIN);
  localparam logic [EW-1:0]      Y_MAX_E  = EW'(Y_MAX);
  localparam logic [EW-1:0]      HIT_E    = EW'(HIT_R);
  localparam logic [COORD_W-1:0] STEP_C   = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] X_MIN_C  = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0] X_MAX_C  = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_MIN_C  = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0] Y_MAX_C  = COORD_W'(Y_MAX);
  localparam logic [COORD_W-1:0] START_XC = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] START_YC = COORD_W'(START_Y);
  localparam logic [3:0]         RIGHT1   = 4'd3;

  // Encoding order makes dir*3 the first animation frame of that direction.
  typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_LEFT, DIR_DOWN} dir_e;

  function automatic logic [3:0] popcount(input logic [N_OBJ-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < N_OBJ; i++) n = n + 4'(v[i]);
    return n;
  endfunction

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [3:0]         state_q, state_d;
  logic [N_OBJ-1:0]   found_q, found_d, hit;
  logic               found_pulse_q, found_pulse_d;
  logic [3:0]         count_q, count_d;
  logic               all_found_q, all_found_d;

  dir_e               dir;
  logic               moving;
  logic [3:0]         base;
  logic [COORD_W-1:0] dx [N_OBJ];
  logic [COORD_W-1:0] dy [N_OBJ];

  always_comb begin : collide
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    hit = '0;
    dx  = '{default: '0};
    dy  = '{default: '0};
    for (int i = 0; i < N_OBJ; i++) begin
      dx[i] = (x_q >= obj_x[i*COORD_W +: COORD_W]) ? x_q - obj_x[i*COORD_W +: COORD_W]
                                                    : obj_x[i*COORD_W +: COORD_W] - x_q;
      dy[i] = (y_q >= obj_y[i*COORD_W +: COORD_W]) ? y_q - obj_y[i*COORD_W +: COORD_W]
                                                    : obj_y[i*COORD_W +: COORD_W] - y_q;
      hit[i] = enable && obj_active[i] && !found_q[i] &&
               ({1'b0, dx[i]} < HIT_E) && ({1'b0, dy[i]} < HIT_E);
    end
  end

  always_comb begin : motion
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    tick_d  = (cnt_q == CNT_LAST);
    x_d     = x_q;
    y_d     = y_q;
    state_d = state_q;

    dir    = DIR_UP;
    moving = 1'b1;
    if      (move_req[0]) dir = DIR_UP;
    else if (move_req[1]) dir = DIR_LEFT;
    else if (move_req[2]) dir = DIR_DOWN;
    else if (move_req[3]) dir = DIR_RIGHT;
    else                  moving = 1'b0;
    base = 4'(dir) * 4'd3;

    if (tick_q && enable) begin
      if (moving) begin
        state_d = (state_q == base + 4'd1) ? base + 4'd2 : base + 4'd1;
        // Clamp tests run one bit wider so the step can never wrap the coordinate.
        unique case (dir)
          DIR_UP:    y_d = ({1'b0, y_q} < Y_MIN_E + STEP_E) ? Y_MIN_C : y_q - STEP_C;
          DIR_DOWN:  y_d = ({1'b0, y_q} + STEP_E > Y_MAX_E) ? Y_MAX_C : y_q + STEP_C;
          DIR_LEFT:  x_d = ({1'b0, x_q} < X_MIN_E + STEP_E) ? X_MIN_C : x_q - STEP_C;
          DIR_RIGHT: x_d = ({1'b0, x_q} + STEP_E > X_MAX_E) ? X_MAX_C : x_q + STEP_C;
          default:   ;
        endcase
      end else begin
        state_d = (state_q / 4'd3) * 4'd3;
      end
    end

    found_d       = found_q | hit;
    found_pulse_d = |hit;
    count_d       = popcount(found_d);
    all_found_d   = (count_d == popcount(obj_active)) && (|obj_active);

    // A stage restart wins over any tick, move or hit arriving in the same cycle.
    if (load_start) begin
      tick_d        = 1'b0;
      x_d           = START_XC;
      y_d           = START_YC;
      state_d       = RIGHT1;
      found_d       = '0;
      found_pulse_d = 1'b0;
      count_d       = '0;
      all_found_d   = 1'b0;
    end
  end

  // NOTE: flops are written only with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      tick_q        <= 1'b0;
      x_q           <= START_XC;
      y_q           <= START_YC;
      state_q       <= RIGHT1;
      found_q       <= '0;
      found_pulse_q <= 1'b0;
      count_q       <= '0;
      all_found_q   <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      tick_q        <= tick_d;
      x_q           <= x_d;
      y_q           <= y_d;
      state_q       <= state_d;
      found_q       <= found_d;
      found_pulse_q <= found_pulse_d;
      count_q       <= count_d;
      all_found_q   <= all_found_d;
    end
  end

  assign player_x     = x_q;
  assign player_y     = y_q;
  assign player_state = state_q;
  assign tick         = tick_q;
  assign found        = found_q;
  assign found_pulse  = found_pulse_q;
  assign found_count  = count_q;
  assign all_found    = all_found_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Scoreboard bench for player_motion_ctrl: stimulus queues expected post-tick positions and
// found events; an independent monitor pops and compares them when the DUT presents them.
module tb_player_motion_ctrl;

  localparam int CW = 9;
  localparam int NO = 3;

  logic             clk = 1'b0;
  logic             rst, enable, load_start;
  logic [3:0]       move_req;
  logic [NO*CW-1:0] obj_x, obj_y;
  logic [NO-1:0]    obj_active;
  logic [CW-1:0]    player_x, player_y;
  logic [3:0]       player_state;
  logic             tick, found_pulse, all_found;
  logic [NO-1:0]    found;
  logic [3:0]       found_count;

  player_motion_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load_start(load_start), .move_req(move_req),
    .obj_x(obj_x), .obj_y(obj_y), .obj_active(obj_active),
    .player_x(player_x), .player_y(player_y), .player_state(player_state), .tick(tick),
    .found(found), .found_pulse(found_pulse), .found_count(found_count), .all_found(all_found)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [CW-1:0] x; logic [CW-1:0] y; logic [3:0] st; } pos_t;
  typedef struct packed { logic [NO-1:0] f; logic [3:0] cnt; logic all; } fnd_t;

  pos_t pos_q[$];
  fnd_t fnd_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 20);
    check("tick_seen", 32'(tick), 32'd1);
  endtask

  // Hold a request over one tick and queue the position/frame expected after it.
  task automatic do_tick(input logic [3:0] mv, input int ex, input int ey, input int est);
    pos_t e;
    move_req = mv;
    wait_tick();
    e.x = CW'(ex);
    e.y = CW'(ey);
    e.st = 4'(est);
    pos_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic push_found(input logic [NO-1:0] f, input int cnt, input logic all);
    fnd_t e;
    e.f = f;
    e.cnt = 4'(cnt);
    e.all = all;
    fnd_q.push_back(e);
  endtask

  task automatic check_restart_state(input string tag);
    check({tag, "_x"}, 32'(player_x), 32'd40);
    check({tag, "_y"}, 32'(player_y), 32'd130);
    check({tag, "_state"}, 32'(player_state), 32'd3);
    check({tag, "_found"}, 32'(found), 32'd0);
    check({tag, "_found_pulse"}, 32'(found_pulse), 32'd0);
    check({tag, "_found_count"}, 32'(found_count), 32'd0);
    check({tag, "_all_found"}, 32'(all_found), 32'd0);
  endtask

  initial begin : monitor
    bit   prev_tick = 1'b0;
    bit   seen = 1'b0;
    int   gap = 0;
    pos_t p;
    fnd_t f;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (prev_tick && pos_q.size() > 0) begin
        p = pos_q.pop_front();
        check("move_x", 32'(player_x), 32'(p.x));
        check("move_y", 32'(player_y), 32'(p.y));
        check("move_state", 32'(player_state), 32'(p.st));
      end
      if (found_pulse) begin
        check("found_event_expected", 32'(fnd_q.size() > 0), 32'd1);
        if (fnd_q.size() > 0) begin
          f = fnd_q.pop_front();
          check("found_flags", 32'(found), 32'(f.f));
          check("found_count", 32'(found_count), 32'(f.cnt));
          check("all_found", 32'(all_found), 32'(f.all));
        end
      end
      gap++;
      if (tick) begin
        if (seen) check("tick_period", 32'(gap), 32'd4);
        seen = 1'b1;
        gap = 0;
      end
      prev_tick = tick;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int n;
    rst = 1'b1; enable = 1'b1; load_start = 1'b0; move_req = 4'b0000;
    obj_x = '0; obj_y = '0; obj_active = '0;
    repeat (3) @(negedge clk);
    check_restart_state("reset");
    check("reset_tick", 32'(tick), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Up held for 10 ticks: frames alternate UP2/UP3 starting from RIGHT1.
    for (int k = 1; k <= 10; k++) do_tick(4'b0001, 40, 130 - k, (k % 2 == 1) ? 1 : 2);
    // Release: idle frame of the last direction, no motion.
    do_tick(4'b0000, 40, 120, 0);
    // Right across to the X_MAX wall, then pinned there.
    for (int k = 1; k <= 262; k++)
      do_tick(4'b1000, (40 + k > 300) ? 300 : 40 + k, 120, (k % 2 == 1) ? 4 : 5);
    // Left beats down.
    do_tick(4'b0110, 299, 120, 7);
    do_tick(4'b0110, 298, 120, 8);
    do_tick(4'b0100, 298, 121, 10);
    // Up beats left.
    do_tick(4'b0011, 298, 120, 1);
    // Disabled: everything holds.
    enable = 1'b0;
    do_tick(4'b0001, 298, 120, 1);
    enable = 1'b1;

    // Restart, then collisions.
    move_req = 4'b0000;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check_restart_state("load");

    obj_x = {9'd60, 9'd40, 9'd50};
    obj_y = {9'd130, 9'd130, 9'd130};
    push_found(3'b001, 1, 1'b0);
    obj_active = 3'b101;          // slot2 sits exactly HIT_R away: no hit
    repeat (4) @(negedge clk);
    check("found_after_a", 32'(found), 32'b001);
    obj_active = 3'b001;
    repeat (2) @(negedge clk);
    check("all_found_one_active", 32'(all_found), 32'd1);
    obj_active = 3'b000;
    repeat (2) @(negedge clk);
    check("found_retained", 32'(found), 32'b001);
    check("all_found_none_active", 32'(all_found), 32'd0);

    obj_x[2*CW +: CW] = 9'd41;
    obj_y[2*CW +: CW] = 9'd149;
    push_found(3'b111, 3, 1'b1);  // two slots hit in the same cycle
    obj_active = 3'b111;
    repeat (3) @(negedge clk);
    check("found_count_after_c", 32'(found_count), 32'd3);

    // load_start landing on a tick cycle with an up request pending.
    obj_active = 3'b000;
    do_tick(4'b0001, 40, 129, 1);
    n = 0;
    while (!tick && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("tick_before_load", 32'(tick), 32'd1);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    move_req = 4'b0000;
    check_restart_state("load_on_tick");

    repeat (8) @(negedge clk);
    check("pos_queue_drained", 32'(pos_q.size()), 32'd0);
    check("found_queue_drained", 32'(fnd_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
Parametrised successor to the in-game player movement logic. Converts one-hot direction requests into prescaled, bounds-clamped player motion, generates the 12-frame walk-animation state, and detects collision against N_OBJ collectable objects, tracking which have been found. Sits between the keyboard/state-machine layer and the renderer; one instance per playable stage context.

Parameters:
COORD_W, 9, coordinate width in bits
TICK_DIV, 1048576, clk cycles per movement tick (>=2)
STEP, 1, pixels moved per tick
X_MIN, 0, lowest legal player_x
X_MAX, 300, highest legal player_x
Y_MIN, 0, lowest legal player_y
Y_MAX, 220, highest legal player_y
START_X, 40, player_x after reset/load_start
START_Y, 130, player_y after reset/load_start
N_OBJ, 3, number of collectable object slots (1..8)
HIT_R, 20, collision half-extent in pixels

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  1 = stage active, movement/collision allowed
load_start  in  1  one-cycle pulse: restart stage
move_req  in  4  one-hot request {right,down,left,up} = bits [3:0]
obj_x  in  N_OBJ*COORD_W  packed object x, slot i at [i*COORD_W +: COORD_W]
obj_y  in  N_OBJ*COORD_W  packed object y, same packing
obj_active  in  N_OBJ  slot i collectable
player_x  out  COORD_W  registered x position
player_y  out  COORD_W  registered y position
player_state  out  4  animation frame: UP1..3=0..2, RIGHT1..3=3..5, LEFT1..3=6..8, DOWN1..3=9..11
tick  out  1  one-cycle pulse at each movement tick
found  out  N_OBJ  sticky per-slot found flags
found_pulse  out  1  one-cycle pulse when any slot newly found
found_count  out  4  popcount of found
all_found  out  1  found_count == popcount(obj_active) and obj_active != 0

Behaviour:
- Reset (rst=1 at clk edge): player_x=START_X, player_y=START_Y, player_state=3 (RIGHT1), prescaler=0, tick=0, found=0, found_pulse=0, found_count=0, all_found=0.
- load_start: identical effect to reset on all outputs next cycle; overrides tick, move and collision in the same cycle.
- Prescaler counts 0..TICK_DIV-1 every cycle regardless of enable; tick=1 for the one cycle after it wraps to 0.
- Movement evaluated only in a cycle where tick=1 and enable=1; position updates next edge (1-cycle latency from tick).
- Multiple move_req bits set: priority up > left > down > right; only one axis moves per tick.
- up: y -= STEP; down: y += STEP; left: x -= STEP; right: x += STEP.
- Clamp: if y < Y_MIN+STEP then y=Y_MIN on up; if y > Y_MAX-STEP then y=Y_MAX on down; same for x. No wrap-around ever; arithmetic done in COORD_W+1 bits.
- Animation on tick&enable: moving in dir d (base b=0/3/6/9): state = b+2 if current==b+1 else b+1. No request: state = (state/3)*3 (idle frame of last direction).
- enable=0: position and player_state hold; found holds.
- Collision each cycle with enable=1: slot i hits when obj_active[i], !found[i], |player_x-obj_x[i]| < HIT_R and |player_y-obj_y[i]| < HIT_R (unsigned magnitude of difference). found[i] set next edge, stays set until rst/load_start.
- Several slots hitting in one cycle: all set together; found_pulse single cycle; found_count jumps by that number.
- found_pulse, found_count, all_found registered, valid same edge as found update.
- obj_active[i] dropped after found[i] set: found[i] retained; all_found recomputed against current obj_active.

Test Plan:
1. TICK_DIV=4, rst then hold move_req=0001 for 40 cycles -> tick every 4 cycles, player_y 130->120 after 10 ticks, player_state alternates 1,2,1,2.
2. Release move_req after case 1 -> next tick player_state=0 (UP1), position unchanged.
3. Start at X_MAX-1=299, move_req=1000 for 3 ticks -> player_x 300, 300, 300; state 4/5 toggling.
4. move_req=0110 (left+down) -> only x decrements; player_state in LEFT2/LEFT3.
5. obj slot0 at (50,130) active, player at (40,130) -> found=001, found_pulse one cycle, found_count=1; slot1,2 inactive -> all_found=1.
6. load_start asserted together with tick and move_req=0001 -> player (40,130), state 3, found=0, no movement that cycle.
